// File: rtl/nco_freq_meter.sv
// nco_freq_meter: recovers the NCO phase increment from a sample stream by counting
// samples over NCYC hysteretic rising zero crossings and dividing NCYC*2^APR by that count.
module nco_freq_meter #(
  parameter int MPR      = 13,
  parameter int APR      = 32,
  parameter int LOG2NCYC = 4,
  parameter int CNTW     = 24,
  parameter int HYST     = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic [MPR-1:0] data_i,
  input  logic           data_valid_i,
  output logic [APR-1:0] phi_inc_o,
  output logic           phi_valid_o,
  output logic           err_o,
  output logic           busy_o
);
  localparam int NCYC = 1 << LOG2NCYC;
  localparam int BW = $clog2(APR + 1);
  localparam logic signed [MPR-1:0] HI = MPR'(HYST);
  localparam logic signed [MPR-1:0] LO = MPR'(-HYST);
  typedef enum logic [1:0] {SEEK, GATE, DIV} state_t;
  state_t r_state, w_next;
  logic r_armed;
  logic [CNTW-1:0] r_s, r_div;
  logic [LOG2NCYC-1:0] r_k;
  logic [CNTW:0] r_rem, w_r2;
  logic [APR-1:0] r_q, w_q;
  logic [BW-1:0] r_bit;
  logic w_take, w_xing, w_ge, w_done, w_err;
  assign w_take = clken & data_valid_i;
  assign w_xing = w_take & r_armed & ($signed(data_i) >= HI);
  // Remainder stays below the divisor, so its top bit is always zero before the shift.
  assign w_r2 = (CNTW+1)'({r_rem, 1'b0});
  assign w_ge = w_r2 >= {1'b0, r_div};
  assign w_q = APR'({r_q, w_ge});
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err = 1'b0;
    if (clken)
      case (r_state)
        SEEK: w_next = w_xing ? GATE : SEEK;
        GATE: begin
          w_err = w_take && !(w_xing && &r_k) && r_s == {{(CNTW-1){1'b1}}, 1'b0};
          w_next = (w_xing && &r_k) ? DIV : w_err ? SEEK : GATE;
        end
        DIV: begin
          w_err = r_bit == '0 && r_div < CNTW'(2 * NCYC);
          w_done = r_bit == BW'(APR);
          w_next = (w_err || w_done) ? SEEK : DIV;
        end
        default: w_next = SEEK;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= SEEK;
      r_armed <= 1'b0;
      r_s <= '0;
      r_k <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_bit <= '0;
      phi_inc_o <= '0;
      phi_valid_o <= 1'b0;
      err_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      phi_valid_o <= w_done;
      err_o <= w_err;
      if (clken) begin
        r_state <= w_next;
        busy_o <= w_next != SEEK;
        if (w_take) r_armed <= ($signed(data_i) <= LO) | (r_armed & ~w_xing);
        case (r_state)
          SEEK: begin
            r_s <= '0;
            r_k <= '0;
          end
          GATE: begin
            if (w_take) r_s <= r_s + 1'b1;
            if (w_xing) r_k <= r_k + 1'b1;
            r_div <= r_s + 1'b1;
            r_rem <= (CNTW+1)'(NCYC);
            r_q <= '0;
            r_bit <= '0;
          end
          DIV: begin
            r_bit <= r_bit + 1'b1;
            if (r_bit != '0) begin
              r_rem <= w_ge ? w_r2 - {1'b0, r_div} : w_r2;
              r_q <= w_q;
            end
            if (w_done) phi_inc_o <= w_q;
          end
          default: r_s <= '0;
        endcase
      end
    end
endmodule

// File: tb/tb_nco_freq_meter.sv
// tb_nco_freq_meter: directed checks of the frequency meter with hand-computed results.
module tb_nco_freq_meter;
  logic clk = 1'b0, reset_n = 1'b1, clken = 1'b0, data_valid_i = 1'b0;
  logic [12:0] data_i = '0;
  logic [31:0] phi_inc_o;
  logic phi_valid_o, err_o, busy_o;
  int checks = 0, failures = 0, n_valid = 0, n_err = 0, en_cnt = 0;
  bit busy_seen = 1'b0;

  nco_freq_meter #(.CNTW(12)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .data_i(data_i),
    .data_valid_i(data_valid_i), .phi_inc_o(phi_inc_o), .phi_valid_o(phi_valid_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ce, input logic v, input logic [12:0] d);
    clken = ce;
    data_valid_i = v;
    data_i = d;
    @(posedge clk);
    #1;
    if (ce) en_cnt++;
    if (phi_valid_o) n_valid++;
    if (err_o) n_err++;
    if (busy_o) busy_seen = 1'b1;
  endtask

  task automatic do_reset;
    clken = 1'b0;
    data_valid_i = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [12:0] sine(int ph);
    return 13'($rtoi(4000.0 * $sin(6.283185307179586 * real'(ph % 100) / 100.0)));
  endfunction

  // 100 samples per period; lat = enabled cycles from the 17th crossing to the result pulse
  task automatic run_sine(input bit gated, output int lat);
    int ph = 0, nx = 0, xe = 0;
    bit tarm = 1'b0, got = 1'b0;
    logic ce, v;
    logic signed [12:0] d;
    lat = -1;
    for (int c = 0; c < 20000 && !got; c++) begin
      ce = gated ? (c % 3 != 0) : 1'b1;
      v = gated ? (c % 2 == 0) : 1'b1;
      d = sine(ph);
      cyc(ce, v, d);
      if (ce && v) begin
        if (d <= -64) tarm = 1'b1;
        else if (d >= 64 && tarm) begin
          tarm = 1'b0;
          nx++;
          if (nx == 17) xe = en_cnt;
        end
        ph++;
      end
      if (phi_valid_o) begin
        got = 1'b1;
        lat = en_cnt - xe;
      end
    end
  endtask

  task automatic run_sq(input int half, input int amp, input int n, input bit stop);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, ((i / half) % 2 == 0) ? 13'(-amp) : 13'(amp));
      if (stop && phi_valid_o) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, v0, e0, cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_phi", phi_inc_o, 0);
    check("rst_valid", phi_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    v0 = n_valid;
    run_sine(1'b0, lat);
    check("t1_phi", phi_inc_o, 32'd42949672);
    check("t1_latency", lat, 33);
    check("t1_busy_seen", busy_seen, 1);
    repeat (40) cyc(1'b1, 1'b0, '0);
    check("t1_pulses", n_valid - v0, 1);
    check("t1_busy_idle", busy_o, 0);

    do_reset;
    check("t2_rst_phi", phi_inc_o, 0);
    v0 = n_valid;
    run_sine(1'b1, lat);
    check("t2_phi", phi_inc_o, 32'd42949672);
    check("t2_latency", lat, 33);
    repeat (40) cyc(1'b1, 1'b0, '0);
    check("t2_pulses", n_valid - v0, 1);

    v0 = n_valid;
    e0 = n_err;
    cyc(1'b1, 1'b1, -13'd100);
    cyc(1'b1, 1'b1, 13'd100);
    check("t3_busy_gate", busy_o, 1);
    cnt = 0;
    while (n_err == e0 && cnt < 5000) begin
      cyc(1'b1, 1'b1, 13'($urandom_range(126)) - 13'd63);
      cnt++;
    end
    check("t3_timeout_samples", cnt, 4095);
    check("t3_err_pulses", n_err - e0, 1);
    check("t3_phi_kept", phi_inc_o, 32'd42949672);
    check("t3_no_valid", n_valid - v0, 0);
    check("t3_busy_after", busy_o, 0);

    v0 = n_valid;
    run_sq(1, 4000, 100, 1'b1);
    check("t4_period2_phi", phi_inc_o, 32'h8000_0000);
    check("t4_period2_pulses", n_valid - v0, 1);

    v0 = n_valid;
    e0 = n_err;
    force dut.w_xing = 1'b1;
    repeat (17) cyc(1'b1, 1'b1, '0);
    release dut.w_xing;
    repeat (3) cyc(1'b1, 1'b0, '0);
    check("t4_under_err", n_err - e0, 1);
    check("t4_under_no_valid", n_valid - v0, 0);
    check("t4_under_phi_kept", phi_inc_o, 32'h8000_0000);
    check("t4_under_busy", busy_o, 0);

    v0 = n_valid;
    run_sq(2, 64, 200, 1'b1);
    check("t4_hyst_edge_phi", phi_inc_o, 32'h4000_0000);
    check("t4_hyst_edge_pulses", n_valid - v0, 1);

    v0 = n_valid;
    run_sq(1, 4000, 16, 1'b0);
    check("t5g_busy", busy_o, 1);
    reset_n = 1'b0;
    #1;
    check("t5g_rst_phi", phi_inc_o, 0);
    check("t5g_rst_busy", busy_o, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("t5g_no_valid", n_valid - v0, 0);
    run_sq(2, 4000, 200, 1'b1);
    check("t5g_after_phi", phi_inc_o, 32'h4000_0000);
    check("t5g_after_pulses", n_valid - v0, 1);

    v0 = n_valid;
    run_sq(1, 4000, 34, 1'b0);
    repeat (11) cyc(1'b1, 1'b0, '0);
    check("t5d_busy", busy_o, 1);
    check("t5d_no_valid", n_valid - v0, 0);
    reset_n = 1'b0;
    #1;
    check("t5d_rst_phi", phi_inc_o, 0);
    check("t5d_rst_busy", busy_o, 0);
    check("t5d_rst_valid", phi_valid_o, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("t5d_abort_no_valid", n_valid - v0, 0);
    run_sq(1, 4000, 100, 1'b1);
    check("t5d_after_phi", phi_inc_o, 32'h8000_0000);

    busy_seen = 1'b0;
    v0 = n_valid;
    e0 = n_err;
    run_sq(1, 63, 300, 1'b0);
    check("t6_busy_never", busy_seen, 0);
    check("t6_no_valid", n_valid - v0, 0);
    check("t6_no_err", n_err - e0, 0);
    check("t6_phi_kept", phi_inc_o, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
